// File: rtl/db_lut_pkg.sv
// ============================================================================
// Module : db_lut_pkg
// Brief  : HEVC deblocking tC/beta tables, index limits and index clipping
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package db_lut_pkg;

  localparam logic signed [7:0] TC_IDX_MAX   = 8'sd53;
  localparam logic signed [7:0] BETA_IDX_MAX = 8'sd51;

  localparam logic [4:0] TC_TABLE [0:53] = '{
    5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,
    5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd1,  5'd1,
    5'd1,  5'd1,  5'd1,  5'd1,  5'd1,  5'd1,  5'd1,  5'd2,  5'd2,  5'd2,
    5'd2,  5'd3,  5'd3,  5'd3,  5'd3,  5'd4,  5'd4,  5'd4,  5'd5,  5'd5,
    5'd6,  5'd6,  5'd7,  5'd8,  5'd9,  5'd10, 5'd11, 5'd13, 5'd14, 5'd16,
    5'd18, 5'd20, 5'd22, 5'd24
  };

  localparam logic [6:0] BETA_TABLE [0:51] = '{
    7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd0,
    7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd6,  7'd7,  7'd8,  7'd9,
    7'd10, 7'd11, 7'd12, 7'd13, 7'd14, 7'd15, 7'd16, 7'd17, 7'd18, 7'd20,
    7'd22, 7'd24, 7'd26, 7'd28, 7'd30, 7'd32, 7'd34, 7'd36, 7'd38, 7'd40,
    7'd42, 7'd44, 7'd46, 7'd48, 7'd50, 7'd52, 7'd54, 7'd56, 7'd58, 7'd60,
    7'd62, 7'd64
  };

  function automatic logic [5:0] clip_idx(input logic signed [7:0] v,
                                          input logic signed [7:0] hi);
    if (v < 8'sd0)
      return 6'd0;
    else if (v > hi)
      return hi[5:0];
    else
      return v[5:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/db_lut_lane.sv
// ============================================================================
// Module : db_lut_lane
// Brief  : one lane of tc/beta index arithmetic (S1) and table lookup (S2);
//          beta path present only when DB_LUT_BETA_EN is defined
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module db_lut_lane
  import db_lut_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int TC_W      = 5 + BIT_DEPTH - 8,
  parameter int BETA_W    = 7 + BIT_DEPTH - 8
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_s1,
  input  logic              ld_s2,
  input  logic [5:0]        qp_p,
  input  logic [5:0]        qp_q,
  input  logic [1:0]        bs,
  input  logic [3:0]        tc_off,
  input  logic [3:0]        beta_off,
  output logic [TC_W-1:0]   tc,
  output logic [BETA_W-1:0] beta,
  output logic [1:0]        bs_out
);

  logic [6:0]        w_qpl;
  logic              w_bs_strong;
  logic signed [7:0] w_tsum;
  logic [5:0]        r_tidx;
  logic [1:0]        r_bs1;
  logic [1:0]        r_bs2;
  logic [TC_W-1:0]   r_tc;
  logic [TC_W-1:0]   w_tc_scaled;

  assign w_qpl       = 7'(({1'b0, qp_p} + {1'b0, qp_q} + 7'd1) >> 1);
  // bs=3 is illegal and behaves exactly like bs=2
  assign w_bs_strong = bs[1];
  assign w_tsum      = signed'({1'b0, w_qpl}) + (w_bs_strong ? 8'sd2 : 8'sd0)
                     + signed'({{3{tc_off[3]}}, tc_off, 1'b0});
  assign w_tc_scaled = TC_W'(TC_TABLE[r_tidx]) << (BIT_DEPTH - 8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tidx <= '0;
      r_bs1  <= '0;
      r_bs2  <= '0;
      r_tc   <= '0;
    end else begin
      if (ld_s1) begin
        r_tidx <= clip_idx(w_tsum, TC_IDX_MAX);
        r_bs1  <= w_bs_strong ? 2'd2 : bs;
      end
      if (ld_s2) begin
        r_bs2 <= r_bs1;
        r_tc  <= (r_bs1 == 2'd0) ? '0 : w_tc_scaled;
      end
    end
  end

  assign tc     = r_tc;
  assign bs_out = r_bs2;

`ifdef DB_LUT_BETA_EN
  logic signed [7:0] w_bsum;
  logic [5:0]        r_bidx;
  logic [BETA_W-1:0] r_beta;

  assign w_bsum = signed'({1'b0, w_qpl}) + signed'({{3{beta_off[3]}}, beta_off, 1'b0});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bidx <= '0;
      r_beta <= '0;
    end else begin
      if (ld_s1) r_bidx <= clip_idx(w_bsum, BETA_IDX_MAX);
      if (ld_s2) r_beta <= BETA_W'(BETA_TABLE[r_bidx]) << (BIT_DEPTH - 8);
    end
  end

  assign beta = r_beta;
`else
  logic w_unused_beta;
  assign w_unused_beta = ^beta_off;
  assign beta          = '0;
`endif

endmodule

`default_nettype wire

// File: rtl/db_lut_tc_beta_pipe.sv
// ============================================================================
// Module : db_lut_tc_beta_pipe
// Brief  : two-stage valid/ready tC/beta threshold pipe over N_CH lanes;
//          beta path built only when DB_LUT_BETA_EN is defined
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module db_lut_tc_beta_pipe #(
  parameter int N_CH      = 4,
  parameter int BIT_DEPTH = 8,
  parameter int TC_W      = 5 + BIT_DEPTH - 8,
  parameter int BETA_W    = 7 + BIT_DEPTH - 8
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [N_CH*6-1:0]      qp_p_i,
  input  logic [N_CH*6-1:0]      qp_q_i,
  input  logic [N_CH*2-1:0]      bs_i,
  input  logic [3:0]             tc_offset_div2_i,
  input  logic [3:0]             beta_offset_div2_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [N_CH*TC_W-1:0]   tc_o,
  output logic [N_CH*BETA_W-1:0] beta_o,
  output logic [N_CH*2-1:0]      bs_o
);

  logic r_s1_valid;
  logic r_out_valid;
  logic w_en1;
  logic w_en2;
  logic w_ld_s1;
  logic w_ld_s2;

  // each stage advances when its downstream slot is empty or draining
  assign w_en2   = !r_out_valid | out_ready_i;
  assign w_en1   = !r_s1_valid | w_en2;
  assign w_ld_s1 = w_en1 & in_valid_i;
  assign w_ld_s2 = w_en2 & r_s1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_en1) r_s1_valid  <= in_valid_i;
      if (w_en2) r_out_valid <= r_s1_valid;
    end
  end

  assign in_ready_o  = w_en1;
  assign out_valid_o = r_out_valid;

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    db_lut_lane #(
      .BIT_DEPTH (BIT_DEPTH),
      .TC_W      (TC_W),
      .BETA_W    (BETA_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .ld_s1    (w_ld_s1),
      .ld_s2    (w_ld_s2),
      .qp_p     (qp_p_i[g*6 +: 6]),
      .qp_q     (qp_q_i[g*6 +: 6]),
      .bs       (bs_i[g*2 +: 2]),
      .tc_off   (tc_offset_div2_i),
      .beta_off (beta_offset_div2_i),
      .tc       (tc_o[g*TC_W +: TC_W]),
      .beta     (beta_o[g*BETA_W +: BETA_W]),
      .bs_out   (bs_o[g*2 +: 2])
    );
  end

endmodule

`default_nettype wire
